reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for reset release; legal range >= 2.
REQ-002 Parameter HOLD, default 16: cycles both output resets stay asserted after synchronized release or soft request; legal range >= 1.
REQ-003 Parameter STAGGER, default 4: cycles between peripheral and core release; legal range >= 1.
REQ-004 Port clk, input, 1: single clock; all state changes on posedge clk except asynchronous reset assertion.
REQ-005 Port reset, input, 1: asynchronous, active-low reset; low forces all state to reset values immediately, independent of clk.
REQ-006 Port sw_req, input, 1: soft reset request, synchronous to clk, active-high.
REQ-007 Port rst_periph, output, 1: active-high reset for peripheral-domain flops, registered.
REQ-008 Port rst_core, output, 1: active-high reset for core-domain flops, registered.
REQ-009 Port rst_done, output, 1: high only while state is RUN, registered.
REQ-010 Port seq_count, output, 8: count of completed reset sequences, registered.

Function
REQ-011 Reset release passes through a SYNC_STAGES-deep flop chain, cleared to 0 by reset, shifting in 1; the chain output is the only path by which reset release reaches the FSM.
REQ-012 FSM states: SYNC, HOLD, PERIPH, RUN; state register async-cleared to SYNC.
REQ-013 SYNC: rst_periph=1, rst_core=1, rst_done=0; when chain output sampled 1 -> HOLD, counter cleared to 0.
REQ-014 HOLD: rst_periph=1, rst_core=1; counter increments each edge; edge where counter == HOLD-1 -> PERIPH, counter cleared.
REQ-015 PERIPH: rst_periph=0, rst_core=1; counter increments; edge where counter == STAGGER-1 -> RUN.
REQ-016 RUN: rst_periph=0, rst_core=0, rst_done=1; remain until sw_req or reset.
REQ-017 sw_req sampled high in RUN -> HOLD with counter 0; rst_periph=1, rst_core=1, rst_done=0 after that same edge.
REQ-018 sw_req ignored in SYNC, HOLD, PERIPH; no counter restart, no sequence extension.
REQ-019 Outputs derived from registered state only; no combinational path from sw_req or reset-release to rst_periph, rst_core, rst_done.
REQ-020 Counter width $clog2(max(HOLD,STAGGER)+1) bits; never wraps within a state.
REQ-021 seq_count increments by 1 on each transition PERIPH -> RUN; saturates at 255.
REQ-022 Latency: edge 1 = first posedge with reset sampled high; rst_periph falls after edge SYNC_STAGES+1+HOLD, rst_core after edge SYNC_STAGES+1+HOLD+STAGGER.
REQ-023 Soft latency: sw_req sampled at edge k -> rst_periph falls after edge k+HOLD, rst_core after edge k+HOLD+STAGGER.
REQ-024 Invariant: rst_core=0 implies rst_periph=0; rst_done=1 iff rst_core=0.

Reset
REQ-025 reset low, at any time including mid-sequence: asynchronously rst_periph=1, rst_core=1, rst_done=0, seq_count=0, state SYNC, counter 0, sync chain 0.
REQ-026 Reset deassertion has no output effect before it has propagated through the full sync chain; a reset pulse shorter than one clock still causes full assertion and a complete sequence.

Verification
REQ-027 Defaults, reset low 3 cycles then high -> rst_periph falls after edge 19, rst_core and rise of rst_done after edge 23, seq_count=1.
REQ-028 In RUN, sw_req one-cycle pulse at edge k -> resets high after edge k, rst_periph low after k+16, rst_core low after k+20, seq_count=2.
REQ-029 sw_req held high continuously from HOLD through PERIPH -> no change to release edges; at first RUN edge with sw_req still high, re-enters HOLD.
REQ-030 reset pulsed low between clock edges during PERIPH -> rst_periph=1, rst_core=1, seq_count=0 asynchronously; full sequence repeats with REQ-027 timing.
REQ-031 256 soft sequences after power-up -> seq_count saturates at 255; rst_done toggles on every sequence.
REQ-032 HOLD=1, STAGGER=1, SYNC_STAGES=3 -> rst_periph falls after edge 5, rst_core after edge 6; REQ-024 invariant checked every cycle in all tests.

Source files
------------

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronizes reset release, then releases the peripheral
// reset and, a few cycles later, the core reset; supports soft re-sequencing.
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD        = 16,
    parameter int STAGGER     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_req,
    output logic       rst_periph,
    output logic       rst_core,
    output logic       rst_done,
    output logic [7:0] seq_count
);

    localparam int MAXC = (HOLD > STAGGER) ? HOLD : STAGGER;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
    localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER - 1);

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_HOLD,
        ST_PERIPH,
        ST_RUN
    } state_t;

    state_t                 state;
    logic [CW-1:0]          count;
    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   released;

    // Reset assertion is immediate; release is only seen through the chain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign released = sync_chain[SYNC_STAGES-1];

    // Output resets are updated on the same edge as the state change they belong to
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_SYNC;
            count      <= '0;
            rst_periph <= 1'b1;
            rst_core   <= 1'b1;
            rst_done   <= 1'b0;
            seq_count  <= 8'd0;
        end else begin
            case (state)
                ST_SYNC: begin
                    if (released) begin
                        state <= ST_HOLD;
                        count <= '0;
                    end
                end
                ST_HOLD: begin
                    if (count == HOLD_LAST) begin
                        state      <= ST_PERIPH;
                        count      <= '0;
                        rst_periph <= 1'b0;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                ST_PERIPH: begin
                    if (count == STAG_LAST) begin
                        state    <= ST_RUN;
                        count    <= '0;
                        rst_core <= 1'b0;
                        rst_done <= 1'b1;
                        if (seq_count != 8'hFF) begin
                            seq_count <= seq_count + 8'd1;
                        end
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                ST_RUN: begin
                    if (sw_req) begin
                        state      <= ST_HOLD;
                        count      <= '0;
                        rst_periph <= 1'b1;
                        rst_core   <= 1'b1;
                        rst_done   <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_SYNC;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: two instances (default and minimal timing) checked
// every cycle against a timeline model of when each reset should be released.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       swReq = 1'b0;
    logic       periphMain, coreMain, doneMain;
    logic [7:0] seqMain;
    logic       periphSmall, coreSmall, doneSmall;
    logic [7:0] seqSmall;

    int  errCount = 0;
    int  checkCount = 0;
    logic checkEn = 1'b0;

    // Per-instance model: edges since release, edge at which the current sequence began
    int pHold[2] = '{16, 1};
    int pStag[2] = '{4, 1};
    int pSync[2] = '{2, 3};
    int mEdge[2];
    int mStart[2];
    int mSeq[2];

    reset_sequencer dut (
        .clk(clk), .reset(reset), .sw_req(swReq),
        .rst_periph(periphMain), .rst_core(coreMain),
        .rst_done(doneMain), .seq_count(seqMain)
    );

    reset_sequencer #(.SYNC_STAGES(3), .HOLD(1), .STAGGER(1)) dutSmall (
        .clk(clk), .reset(reset), .sw_req(swReq),
        .rst_periph(periphSmall), .rst_core(coreSmall),
        .rst_done(doneSmall), .seq_count(seqSmall)
    );

    always #5 clk = ~clk;

    function automatic logic expPeriph(int i);
        return (mEdge[i] < mStart[i]) || ((mEdge[i] - mStart[i]) < pHold[i]);
    endfunction

    function automatic logic expCore(int i);
        return (mEdge[i] < mStart[i]) || ((mEdge[i] - mStart[i]) < pHold[i] + pStag[i]);
    endfunction

    // A sequence starts SYNC_STAGES+1 edges after release, or on a soft request seen in run
    always @(posedge clk or negedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                mEdge[i]  = 0;
                mStart[i] = pSync[i] + 1;
                mSeq[i]   = 0;
            end else begin
                mEdge[i] = mEdge[i] + 1;
                if (mEdge[i] > mStart[i] && (mEdge[i] - 1 - mStart[i]) >= pHold[i] + pStag[i] && swReq)
                    mStart[i] = mEdge[i];
                else if (mEdge[i] - mStart[i] == pHold[i] + pStag[i] && mSeq[i] < 255)
                    mSeq[i] = mSeq[i] + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareDut(input int i, input logic p, input logic c, input logic d, input logic [7:0] s);
        checkOutput($sformatf("periph%0d", i), 32'(p), 32'(expPeriph(i)));
        checkOutput($sformatf("core%0d", i), 32'(c), 32'(expCore(i)));
        checkOutput($sformatf("done%0d", i), 32'(d), 32'(!expCore(i)));
        checkOutput($sformatf("seq%0d", i), 32'(s), 32'(mSeq[i]));
        checkOutput($sformatf("invCorePeriph%0d", i), 32'(!c && p), 32'd0);
        checkOutput($sformatf("invDone%0d", i), 32'(d), 32'(!c));
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            compareDut(0, periphMain, coreMain, doneMain, seqMain);
            compareDut(1, periphSmall, coreSmall, doneSmall, seqSmall);
        end
    end

    // Assumes reset was just released and the next posedge is edge 1
    task automatic checkReleaseTiming();
        for (int e = 1; e <= 26; e++) begin
            @(posedge clk); #1;
            case (e)
                4:  checkOutput("smallPeriphE4", 32'(periphSmall), 32'd1);
                5: begin
                    checkOutput("smallPeriphE5", 32'(periphSmall), 32'd0);
                    checkOutput("smallCoreE5", 32'(coreSmall), 32'd1);
                end
                6:  checkOutput("smallCoreE6", 32'(coreSmall), 32'd0);
                18: checkOutput("periphE18", 32'(periphMain), 32'd1);
                19: begin
                    checkOutput("periphE19", 32'(periphMain), 32'd0);
                    checkOutput("coreE19", 32'(coreMain), 32'd1);
                end
                22: checkOutput("coreE22", 32'(coreMain), 32'd1);
                23: begin
                    checkOutput("coreE23", 32'(coreMain), 32'd0);
                    checkOutput("doneE23", 32'(doneMain), 32'd1);
                    checkOutput("seqE23", 32'(seqMain), 32'd1);
                end
                default: ;
            endcase
        end
    endtask

    task automatic waitDone(input int budget);
        for (int j = 0; j < budget; j++) begin
            @(posedge clk); #1;
            if (doneMain) break;
        end
        checkOutput("waitDone", 32'(doneMain), 32'd1);
    endtask

    task automatic pulseSoft();
        swReq = 1'b1;
        @(posedge clk); #1;
        swReq = 1'b0;
    endtask

    task automatic applyStimulus();
        // Power-up reset held for three cycles
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkEn = 1'b1;
        checkOutput("rstPeriph", 32'(periphMain), 32'd1);
        checkOutput("rstCore", 32'(coreMain), 32'd1);
        checkOutput("rstDone", 32'(doneMain), 32'd0);
        checkOutput("rstSeq", 32'(seqMain), 32'd0);
        reset = 1'b1;
        checkReleaseTiming();

        // Single-cycle soft request in run
        pulseSoft();
        checkOutput("softPeriphK", 32'(periphMain), 32'd1);
        checkOutput("softDoneK", 32'(doneMain), 32'd0);
        for (int j = 1; j <= 20; j++) begin
            @(posedge clk); #1;
            if (j == 15) checkOutput("softPeriphK15", 32'(periphMain), 32'd1);
            if (j == 16) checkOutput("softPeriphK16", 32'(periphMain), 32'd0);
            if (j == 19) checkOutput("softCoreK19", 32'(coreMain), 32'd1);
            if (j == 20) begin
                checkOutput("softCoreK20", 32'(coreMain), 32'd0);
                checkOutput("softSeqK20", 32'(seqMain), 32'd2);
            end
        end

        // Soft request held through a whole sequence
        swReq = 1'b1;
        @(posedge clk); #1;
        for (int j = 1; j <= 21; j++) begin
            @(posedge clk); #1;
            if (j == 16) checkOutput("heldPeriphK16", 32'(periphMain), 32'd0);
            if (j == 20) checkOutput("heldDoneK20", 32'(doneMain), 32'd1);
            if (j == 21) begin
                checkOutput("heldDoneK21", 32'(doneMain), 32'd0);
                checkOutput("heldPeriphK21", 32'(periphMain), 32'd1);
            end
        end
        swReq = 1'b0;
        waitDone(40);

        // Short reset pulse between edges while in the peripheral-release phase
        pulseSoft();
        repeat (17) @(posedge clk);
        #1;
        checkOutput("midPeriph", 32'(periphMain), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("asyncPeriph", 32'(periphMain), 32'd1);
        checkOutput("asyncCore", 32'(coreMain), 32'd1);
        checkOutput("asyncSeq", 32'(seqMain), 32'd0);
        #1;
        reset = 1'b1;
        checkReleaseTiming();

        // Random soft requests with occasional reset glitches
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            swReq = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                #2;
                reset = 1'b1;
            end
        end
        swReq = 1'b0;

        // Saturation of the sequence counter
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        waitDone(40);
        for (int n = 0; n < 256; n++) begin
            pulseSoft();
            waitDone(40);
        end
        checkOutput("satMain", 32'(seqMain), 32'd255);
        checkOutput("satSmall", 32'(seqSmall), 32'd255);
    endtask

    initial begin
        applyStimulus();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
